// File: rtl/memory_mp.sv
// rtl/memory_mp.sv - multi-read, dual-write memory with self-initialisation
module memory_mp #(
  parameter int                    N_ELEMENTS   = 128,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    N_RD         = 2,
  parameter int                    READ_LATENCY = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RD*ADDR_WIDTH-1:0]   r_addr,
  output logic [N_RD*DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]                   w_en,
  input  logic [ADDR_WIDTH-1:0]        w_addr_0,
  input  logic [ADDR_WIDTH-1:0]        w_addr_1,
  input  logic [DATA_WIDTH-1:0]        w_data_0,
  input  logic [DATA_WIDTH-1:0]        w_data_1,
  output logic                         ready,
  output logic                         w_conflict,
  output logic                         addr_err
);

  localparam int                  PTR_W    = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(N_ELEMENTS - 1);
  localparam logic [ADDR_WIDTH:0] N_EL_A   = (ADDR_WIDTH + 1)'(N_ELEMENTS);

  logic [DATA_WIDTH-1:0] mem_q [N_ELEMENTS];

  logic [PTR_W-1:0] init_ptr_q, init_ptr_d;
  logic             ready_q, ready_d;
  logic             w_conflict_q, w_conflict_d;
  logic             addr_err_q, addr_err_d;

  logic             wr0, wr1, dual_same;
  logic             w_oor;
  logic             rd_oor;

  logic [N_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [N_RD-1:0]                 rd_inr;
  logic [N_RD-1:0][DATA_WIDTH-1:0] rd_word;

  // Write-port decode: only in-range writes after init count; port 1 wins a same-address pair.
  always_comb begin
    logic inr0, inr1;
    inr0      = ({1'b0, w_addr_0} < N_EL_A);
    inr1      = ({1'b0, w_addr_1} < N_EL_A);
    dual_same = ready_q && w_en[0] && w_en[1] && inr0 && inr1 && (w_addr_0 == w_addr_1);
    wr1       = ready_q && w_en[1] && inr1;
    wr0       = ready_q && w_en[0] && inr0 && !dual_same;
    w_oor     = ready_q && ((w_en[0] && !inr0) || (w_en[1] && !inr1));
  end

  // Per-port read lookup; nothing is visible until init has finished.
  always_comb begin
    rd_oor = 1'b0;
    for (int k = 0; k < N_RD; k++) begin
      rd_addr[k] = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_inr[k]  = ({1'b0, rd_addr[k]} < N_EL_A);
      rd_word[k] = (ready_q && rd_inr[k]) ? mem_q[rd_addr[k][PTR_W-1:0]] : '0;
      if (ready_q && !rd_inr[k]) begin
        rd_oor = 1'b1;
      end
    end
  end

  // Next state for the init sequencer and status flags.
  always_comb begin
    init_ptr_d   = init_ptr_q;
    ready_d      = ready_q;
    w_conflict_d = 1'b0;
    addr_err_d   = addr_err_q;
    if (!ready_q) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_PTR) begin
        ready_d = 1'b1;
      end
    end else begin
      w_conflict_d = dual_same;
      if (w_oor || rd_oor) begin
        addr_err_d = 1'b1;
      end
    end
  end

  // Control registers; reset restarts the init sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      w_conflict_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      init_ptr_q   <= init_ptr_d;
      ready_q      <= ready_d;
      w_conflict_q <= w_conflict_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Storage: init fill while not ready, then the two write ports (port 1 last so it wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready_q) begin
        mem_q[init_ptr_q] <= INIT_VALUE;
      end else begin
        if (wr0) begin
          mem_q[w_addr_0[PTR_W-1:0]] <= w_data_0;
        end
        if (wr1) begin
          mem_q[w_addr_1[PTR_W-1:0]] <= w_data_1;
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_rd_reg
      logic [N_RD-1:0][DATA_WIDTH-1:0] rd_wf;
      logic [N_RD-1:0][DATA_WIDTH-1:0] rd_q;

      // Write-first bypass so a same-cycle write is what the registered read captures.
      always_comb begin
        for (int k = 0; k < N_RD; k++) begin
          rd_wf[k] = rd_word[k];
          if (wr1 && (w_addr_1 == rd_addr[k])) begin
            rd_wf[k] = w_data_1;
          end else if (wr0 && (w_addr_0 == rd_addr[k])) begin
            rd_wf[k] = w_data_0;
          end
        end
      end

      // Registered read data, cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_wf;
        end
      end

      assign r_data = rd_q;
    end else begin : g_rd_comb
      assign r_data = rd_word;
    end
  endgenerate

  assign ready      = ready_q;
  assign w_conflict = w_conflict_q;
  assign addr_err   = addr_err_q;

endmodule
